// File: rtl/inbuff_pkg.sv
// Shared definitions for the CNN input-buffer writer: FSM states, buffer
// geometry, pad_edge bit positions and padded-size helpers.
package inbuff_pkg;

  localparam int INBUFF_DEPTH = 512;
  localparam int INBUFF_AW    = 9;

  // Bit positions inside pad_edge = {top, bot, lef, rig}
  localparam int PAD_TOP = 3;
  localparam int PAD_BOT = 2;
  localparam int PAD_LEF = 1;
  localparam int PAD_RIG = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  // Unpadded dimension plus the two optional one-word borders
  function automatic logic [10:0] padded_dim(input logic [9:0] dim,
                                             input logic       pad_a,
                                             input logic       pad_b);
    return {1'b0, dim} + {10'd0, pad_a} + {10'd0, pad_b};
  endfunction

  // Padded tile size, evaluated only when a tile is accepted
  function automatic logic [19:0] padded_total(input logic [10:0] wp,
                                               input logic [10:0] hp);
    return {9'd0, wp} * {9'd0, hp};
  endfunction

endpackage

// File: rtl/inbuff_writer_if.sv
// Beat stream from the tile loader plus the BRAM write port.
// master = tile loader / BRAM side, slave = inbuff_writer.
interface inbuff_writer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output s_data, s_valid,
    input  s_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  s_data, s_valid,
    output s_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/inbuff_pos_cnt.sv
// Column/row position counters of the padded tile. Advance on i_adv,
// wrap the column at i_col_max and flag the first/last row and column.
module inbuff_pos_cnt #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_adv,
  input  logic [CNT_W-1:0] i_col_max,
  input  logic [CNT_W-1:0] i_row_max,
  output logic             o_first_col,
  output logic             o_first_row,
  output logic             o_last_col,
  output logic             o_last_row,
  output logic             o_last
);

  logic [CNT_W-1:0] r_col;
  logic [CNT_W-1:0] r_row;

  assign o_first_col = (r_col == '0);
  assign o_first_row = (r_row == '0);
  assign o_last_col  = (r_col == i_col_max);
  assign o_last_row  = (r_row == i_row_max);
  assign o_last      = o_last_col & o_last_row;

  // Step the position row-major; clear at the start of every tile
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_clear) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_adv) begin
      if (o_last_col) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/inbuff_writer.sv
// Write-side address generator for the CNN input buffer. Pads one tile
// with zero rows/columns as selected by pad_edge and writes it row-major,
// address = row*Wp + col, using an incrementing address counter.
// Optional build macro INBUFF_PINGPONG_EN adds bank_free/wr_bank and
// alternates the target bank on every finished tile.
module inbuff_writer
  import inbuff_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = INBUFF_AW,
  parameter int DEPTH  = INBUFF_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] ifm_L,
  input  logic [9:0] ifm_H,
  input  logic [3:0] pad_edge,
`ifdef INBUFF_PINGPONG_EN
  input  logic [1:0] bank_free,
  output logic       wr_bank,
`endif
  inbuff_writer_if.slave bus,
  output logic       busy,
  output logic       done_tile,
  output logic       err_overflow
);

  state_t            r_state;
  logic [9:0]        r_wp;
  logic [9:0]        r_hp;
  logic [3:0]        r_pad;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
`ifdef INBUFF_PINGPONG_EN
  logic              r_bank;
`endif

  logic [10:0] w_wp;
  logic [10:0] w_hp;
  logic [19:0] w_total;
  logic        w_overflow;
  logic        w_bank_ok;
  logic        w_accept;
  logic        w_in_fill;
  logic        w_pad;
  logic        w_adv;
  logic        w_first_col;
  logic        w_first_row;
  logic        w_last_col;
  logic        w_last_row;
  logic        w_last;

  // Padded geometry of the tile being offered on start
  assign w_wp       = padded_dim(ifm_L, pad_edge[PAD_LEF], pad_edge[PAD_RIG]);
  assign w_hp       = padded_dim(ifm_H, pad_edge[PAD_TOP], pad_edge[PAD_BOT]);
  assign w_total    = padded_total(w_wp, w_hp);
  assign w_overflow = (w_total > 20'(DEPTH));

`ifdef INBUFF_PINGPONG_EN
  assign w_bank_ok = bank_free[r_bank];
  assign wr_bank   = r_bank;
`else
  assign w_bank_ok = 1'b1;
`endif

  assign w_accept  = start & (r_state == IDLE) & w_bank_ok;
  assign w_in_fill = (r_state == FILL);

  // Pad positions self-advance; data positions wait for a handshake
  assign w_pad = (w_first_row & r_pad[PAD_TOP]) |
                 (w_last_row  & r_pad[PAD_BOT]) |
                 (w_first_col & r_pad[PAD_LEF]) |
                 (w_last_col  & r_pad[PAD_RIG]);
  assign w_adv = w_in_fill & (w_pad | bus.s_valid);

  assign bus.s_ready  = w_in_fill & ~w_pad;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign busy         = r_busy;
  assign done_tile    = r_done;
  assign err_overflow = r_err;

  inbuff_pos_cnt #(.CNT_W(10)) u_pos_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_accept),
    .i_adv      (w_adv),
    .i_col_max  (r_wp - 10'd1),
    .i_row_max  (r_hp - 10'd1),
    .o_first_col(w_first_col),
    .o_first_row(w_first_row),
    .o_last_col (w_last_col),
    .o_last_row (w_last_row),
    .o_last     (w_last)
  );

  // Tile FSM with registered write port and status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_wp      <= '0;
      r_hp      <= '0;
      r_pad     <= '0;
      r_addr    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
`ifdef INBUFF_PINGPONG_EN
      r_bank    <= 1'b0;
`endif
    end else begin
      // NOTE: strobes get their idle value first each cycle so a write or
      // done pulse can never be held over from a previous cycle.
      r_wr_en <= w_adv;
      r_done  <= 1'b0;

      if (w_adv) begin
        r_wr_addr <= r_addr;
        r_wr_data <= w_pad ? '0 : bus.s_data;
        r_addr    <= r_addr + 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_wp   <= w_wp[9:0];
            r_hp   <= w_hp[9:0];
            r_pad  <= pad_edge;
            r_addr <= '0;
            r_err  <= w_overflow;
            r_busy <= 1'b1;
            if (w_overflow) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= FILL;
            end
          end
        end
        FILL: begin
          if (w_adv && w_last) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
`ifdef INBUFF_PINGPONG_EN
          r_bank  <= ~r_bank;
`endif
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inbuff_writer.sv
// Self-checking bench for inbuff_writer. A behavioural model walks the
// padded tile position by position against the same s_valid schedule the
// driver uses and predicts every write (address, data, cycle) and done_tile.
module tb_inbuff_writer;
  import inbuff_pkg::*;

  localparam int DW = 32;
  localparam int AW = 9;
  localparam int BUDGET = 3000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [9:0] ifm_L = '0;
  logic [9:0] ifm_H = '0;
  logic [3:0] pad_edge = '0;
  logic       busy;
  logic       done_tile;
  logic       err_overflow;
`ifdef INBUFF_PINGPONG_EN
  logic [1:0] bank_free = 2'b11;
  logic       wr_bank;
`endif

  inbuff_writer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  inbuff_writer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(512)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .ifm_L       (ifm_L),
    .ifm_H       (ifm_H),
    .pad_edge    (pad_edge),
`ifdef INBUFF_PINGPONG_EN
    .bank_free   (bank_free),
    .wr_bank     (wr_bank),
`endif
    .bus         (bus),
    .busy        (busy),
    .done_tile   (done_tile),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic        valid_seq[BUDGET];
  logic [31:0] beats[1024];

  // Observed results of one tile
  int          o_addr[$];
  logic [31:0] o_data[$];
  int          o_cyc[$];
  int          o_done_cyc;
  int          o_ready_lo;
  logic        o_busy_after;
  logic        o_done_after;
  logic        o_err_at_done;
  logic        o_err_after;
  bit          o_timeout;

  // Expected results of one tile
  int          e_addr[$];
  logic [31:0] e_data[$];
  int          e_cyc[$];
  int          e_done_cyc;
  int          e_ready_lo;
  bit          e_ovf;

  // Reference: enumerate the padded tile row-major with plain arithmetic
  task automatic build_expected(input int L, input int H, input logic [3:0] pad);
    int wp, hp, t, k;
    bit is_pad;
    e_addr.delete(); e_data.delete(); e_cyc.delete();
    wp = L + int'(pad[PAD_LEF]) + int'(pad[PAD_RIG]);
    hp = H + int'(pad[PAD_TOP]) + int'(pad[PAD_BOT]);
    e_ovf = (wp * hp > 512);
    e_ready_lo = 0;
    e_done_cyc = 0;
    if (e_ovf) return;
    t = 0; k = 0;
    for (int r = 0; r < hp; r++) begin
      for (int c = 0; c < wp; c++) begin
        is_pad = (pad[PAD_TOP] && r == 0) || (pad[PAD_BOT] && r == hp - 1) ||
                 (pad[PAD_LEF] && c == 0) || (pad[PAD_RIG] && c == wp - 1);
        if (is_pad) e_ready_lo++;
        else while (t < BUDGET - 1 && !valid_seq[t]) t++;
        e_addr.push_back(r * wp + c);
        e_data.push_back(is_pad ? 32'd0 : beats[k]);
        if (!is_pad) k++;
        e_cyc.push_back(t + 1);
        t++;
      end
    end
    e_done_cyc = t;
  endtask

  // Start one tile and record everything the DUT does until done_tile+1.
  // Cycle 0 is the first cycle after the start edge.
  task automatic drive_tile(input int L, input int H, input logic [3:0] pad,
                            input int restart_at);
    int k;
    k = 0;
    o_addr.delete(); o_data.delete(); o_cyc.delete();
    o_done_cyc = -1; o_ready_lo = 0; o_timeout = 1'b1;
    o_busy_after = 1'bx; o_done_after = 1'bx;
    o_err_at_done = 1'bx; o_err_after = 1'bx;
    @(negedge clk);
    start = 1'b1; ifm_L = 10'(L); ifm_H = 10'(H); pad_edge = pad;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      if (bus.wr_en) begin
        o_addr.push_back(int'(bus.wr_addr));
        o_data.push_back(bus.wr_data);
        o_cyc.push_back(c);
      end
      if (o_done_cyc >= 0 && c == o_done_cyc + 1) begin
        o_busy_after = busy; o_done_after = done_tile; o_err_after = err_overflow;
        o_timeout = 1'b0;
        break;
      end
      if (done_tile && o_done_cyc < 0) begin
        o_done_cyc = c; o_err_at_done = err_overflow;
      end
      if (busy && !done_tile && !bus.s_ready) o_ready_lo++;
      start = (c == restart_at);
      if (start) begin ifm_L = 10'd1; ifm_H = 10'd1; pad_edge = 4'hF; end
      bus.s_valid = valid_seq[c];
      bus.s_data  = beats[k];
      if (bus.s_valid && bus.s_ready && k < 1023) k++;
      @(negedge clk);
    end
    start = 1'b0;
    bus.s_valid = 1'b0;
  endtask

  // Run one tile and compare every write, the done timing and status flags
  task automatic test_tile_stream(input string name, input int L, input int H,
                                  input logic [3:0] pad, input int restart_at);
    int n;
    build_expected(L, H, pad);
    drive_tile(L, H, pad, restart_at);
    n_checks++;
    if (o_timeout !== 1'b0) begin
      n_fail++; $display("FAIL %s timeout: no done_tile within %0d cycles", name, BUDGET);
    end
    n_checks++;
    if (o_addr.size() != e_addr.size()) begin
      n_fail++; $display("FAIL %s write_count: got %0d expected %0d", name, o_addr.size(), e_addr.size());
    end
    n = (o_addr.size() < e_addr.size()) ? o_addr.size() : e_addr.size();
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (o_addr[i] != e_addr[i] || o_data[i] !== e_data[i] || o_cyc[i] != e_cyc[i]) begin
        n_fail++;
        $display("FAIL %s write[%0d]: got addr=%0d data=%h cyc=%0d expected addr=%0d data=%h cyc=%0d",
                 name, i, o_addr[i], o_data[i], o_cyc[i], e_addr[i], e_data[i], e_cyc[i]);
      end
    end
    n_checks++;
    if (o_done_cyc != e_done_cyc) begin
      n_fail++; $display("FAIL %s done_cycle: got %0d expected %0d", name, o_done_cyc, e_done_cyc);
    end
    n_checks++;
    if (o_busy_after !== 1'b0 || o_done_after !== 1'b0) begin
      n_fail++; $display("FAIL %s after_done: got busy=%b done=%b expected 0 0", name, o_busy_after, o_done_after);
    end
    n_checks++;
    if (o_err_at_done !== e_ovf) begin
      n_fail++; $display("FAIL %s err_overflow: got %b expected %b", name, o_err_at_done, e_ovf);
    end
    n_checks++;
    if (o_ready_lo != e_ready_lo) begin
      n_fail++; $display("FAIL %s ready_low_cycles: got %0d expected %0d", name, o_ready_lo, e_ready_lo);
    end
  endtask

  task automatic set_valid(input int mode);
    for (int c = 0; c < BUDGET; c++)
      case (mode)
        0:       valid_seq[c] = 1'b1;
        1:       valid_seq[c] = (c % 2 == 0);
        default: valid_seq[c] = ($urandom_range(0, 9) < 7) || (c > BUDGET / 2);
      endcase
  endtask

  task automatic set_beats(input int mode, input int base);
    for (int k = 0; k < 1024; k++) beats[k] = (mode == 0) ? 32'(base + k) : $urandom;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({bus.s_ready, bus.wr_en, busy, done_tile, err_overflow} !== 5'b0 ||
        bus.wr_addr !== '0 || bus.wr_data !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got ready=%b wr_en=%b addr=%0d data=%h busy=%b done=%b err=%b expected all 0",
               bus.s_ready, bus.wr_en, bus.wr_addr, bus.wr_data, busy, done_tile, err_overflow);
    end
  endtask

  task automatic test_unpadded();
    set_valid(0); set_beats(0, 0);
    test_tile_stream("unpadded", 4, 3, 4'b0000, -1);
    n_checks++;
    if (o_done_cyc != 12) begin
      n_fail++; $display("FAIL unpadded_done: got cycle %0d expected 12", o_done_cyc);
    end
  endtask

  task automatic test_full_pad();
    set_valid(0); set_beats(0, 100);
    test_tile_stream("full_pad", 2, 2, 4'b1111, -1);
    n_checks++;
    if (o_ready_lo != 12) begin
      n_fail++; $display("FAIL full_pad_ready_low: got %0d expected 12", o_ready_lo);
    end
  endtask

  task automatic test_backpressure();
    set_valid(1); set_beats(1, 0);
    test_tile_stream("backpressure", 3, 2, 4'b0000, -1);
  endtask

  task automatic test_overflow();
    set_valid(0); set_beats(1, 0);
    test_tile_stream("overflow", 30, 20, 4'b0000, -1);
    n_checks++;
    if (o_err_after !== 1'b1) begin
      n_fail++; $display("FAIL overflow_sticky: got err=%b expected 1", o_err_after);
    end
    test_tile_stream("overflow_clear", 2, 2, 4'b0100, -1);
  endtask

  task automatic test_ignored_start();
    set_valid(2); set_beats(1, 0);
    test_tile_stream("ignored_start", 5, 4, 4'b0101, 6);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      set_valid(2); set_beats(1, 0);
      test_tile_stream($sformatf("random%0d", i), $urandom_range(1, 24),
                       $urandom_range(1, 24), 4'($urandom_range(0, 15)), -1);
    end
  endtask

  task automatic test_async_reset();
    set_valid(0); set_beats(1, 0);
    @(negedge clk);
    start = 1'b1; ifm_L = 10'd8; ifm_H = 10'd8; pad_edge = 4'b0000;
    @(negedge clk);
    start = 1'b0; bus.s_valid = 1'b1;
    repeat (20) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.s_ready, bus.wr_en, busy, done_tile, err_overflow} !== 5'b0 ||
        bus.wr_addr !== '0 || bus.wr_data !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got ready=%b wr_en=%b addr=%0d data=%h busy=%b done=%b expected all 0",
               bus.s_ready, bus.wr_en, bus.wr_addr, bus.wr_data, busy, done_tile);
    end
    bus.s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (done_tile !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: got done=%b busy=%b expected 0 0", done_tile, busy);
    end
    set_beats(1, 0);
    test_tile_stream("after_reset", 1, 1, 4'b0000, -1);
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_unpadded();
    test_full_pad();
    test_backpressure();
    test_overflow();
    test_ignored_start();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/inbuff_writer.md
Name: inbuff_writer

Overview:
- Write-side address generator for the CNN input buffer BRAM (512 x DATA_W).
- Accepts one feature-map tile as a valid/ready beat stream from the tile loader.
- Inserts zero padding on the sides selected by pad_edge and writes the padded tile row-major, so that address = row*(ifm_L+pad_lef+pad_rig) + col.
- This is the layout the sliding-window read-address generator consumes.

Parameters:
- DATA_W, 32: BRAM word width (packed 4-bit activations).
- ADDR_W, 9: BRAM address width.
- DEPTH, 512: BRAM words per bank; tiles larger than this are rejected.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle pulse that begins a tile; ignored unless idle.
- ifm_L  in  10  unpadded tile width, 1..511.
- ifm_H  in  10  unpadded tile height, 1..511.
- pad_edge  in  4  {top, bot, lef, rig}, each 1 row/column of zeros.
- s_data  in  DATA_W  input beat.
- s_valid  in  1  beat valid.
- s_ready  out  1  beat accepted when s_valid&s_ready.
- wr_en  out  1  BRAM write strobe.
- wr_addr  out  ADDR_W  BRAM write address.
- wr_data  out  DATA_W  BRAM write data; zero on pad positions.
- busy  out  1  high from the start-accept cycle until the done_tile cycle inclusive.
- done_tile  out  1  one-cycle pulse after the last write of the tile.
- err_overflow  out  1  sticky; set when padded W*H > DEPTH; cleared by the next accepted start.

Behaviour:
- Reset values: s_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done_tile=0, err_overflow=0; FSM in IDLE.
- On start, all tile parameters are latched:
  - Wp = ifm_L+lef+rig.
  - Hp = ifm_H+top+bot.
  - total = Wp*Hp, computed at 20 bits.
- FSM states: IDLE, FILL, DONE.
- IDLE -> FILL on start when total <= DEPTH.
- IDLE -> DONE on start when total > DEPTH: err_overflow is set and no writes occur.
- FILL holds a column counter col (0..Wp-1) and a row counter row (0..Hp-1). The address is incremental (addr+1 per position); no multiplier is used in the datapath.
- A position is pad when any of these holds:
  - row==0 and top.
  - row==Hp-1 and bot.
  - col==0 and lef.
  - col==Wp-1 and rig.
- Pad position: s_ready=0 and the position advances every cycle, writing zero.
- Data position: s_ready=1 and the position advances only on s_valid&s_ready, writing s_data.
- s_ready is combinational from state and position; it is never high in IDLE or DONE.
- Write latency: wr_en/wr_addr/wr_data are registered, one cycle after the position advances. wr_en=0 in every non-advancing cycle.
- Counter wrap: col reaches Wp-1 -> col=0, row+1. The last position (row==Hp-1, col==Wp-1) advancing moves FILL -> DONE.
- DONE: done_tile=1 for exactly one cycle, then IDLE.
  - The last wr_en and done_tile occur in the same cycle.
  - In the overflow case, DONE follows start by 1 cycle with no wr_en.
- start while busy: ignored, with no parameter relatch.
- Back-to-back: start may be accepted in the cycle after done_tile.
- Asynchronous reset mid-FILL: all outputs return to reset values immediately. The partial tile is abandoned and no done_tile is issued.
- Beats presented while s_ready=0 are not consumed; the source must hold them.

Optional Feature:
- Macro: INBUFF_PINGPONG_EN.
- With the macro defined:
  - Extra ports bank_free (in, 2) and wr_bank (out, 1).
  - Each tile writes to bank wr_bank.
  - start is accepted only when bank_free[next_bank] is 1.
  - wr_bank toggles on each done_tile, including overflow tiles; its reset value is 0.
- Without the macro: neither port exists, and the single bank is always writable.

Decomposition:
- Shared package inbuff_pkg holds:
  - the FSM state enum (IDLE/FILL/DONE);
  - the constants INBUFF_DEPTH=512 and INBUFF_AW=9;
  - the pad_edge bit indices PAD_TOP=3, PAD_BOT=2, PAD_LEF=1, PAD_RIG=0.
- One natural sub-module, inbuff_pos_cnt: the col/row counters with wrap and last-position flag, enabled by an advance strobe.

Test Plan:
- Unpadded tile: L=4, H=3, pad_edge=0, s_valid held 1, data=k for beat k. Required: 12 writes at addr 0..11 with data 0..11, consecutive cycles, done_tile with the last write, busy low the next cycle.
- Full padding: L=2, H=2, pad_edge=4'b1111. Required: 16 writes at addr 0..15; data beats land at 5, 6, 9, 10; all other writes are zero; s_ready low during the 12 pad cycles.
- Backpressure: L=3, H=2, pad_edge=0, s_valid toggling 1,0,1,0. Required: 6 writes at addr 0..5 in order, no wr_en during gap cycles, no duplicate or skipped address.
- Overflow: L=30, H=20, pad 0 (600>512). Required: err_overflow=1, zero writes, done_tile 1 cycle after start; the next valid start clears err_overflow.
- Reset and ignored start:
  - Start during FILL is ignored: the address sequence continues unchanged.
  - rst low mid-tile: outputs go to zero immediately; after release, a new start with L=1, H=1 writes addr 0 only.
